// File: rtl/uart_rx_top.sv
// uart_rx_top: UART receiver with 16x oversampling and a show-ahead receive FIFO.
// Frames are 8N1 by default. Defining RX_PARITY_EN switches the frame to 8E1,
// adds a PARITY state and the parity_error output.
//
// state     | meaning
// S_IDLE    | line idle, waiting for rx_s to go low
// S_START   | confirming the start bit at its middle (8th tick)
// S_DATA    | sampling 8 data bits LSB first, one every 16 ticks
// S_PARITY  | sampling the even parity bit (RX_PARITY_EN only)
// S_STOP    | sampling the stop bit, deciding write / overrun / framing error
// S_WAIT    | after a framing error, waiting for the line to return high
module uart_rx_top #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 19200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   input  logic       read_enable,
   output logic [7:0] dout,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       rx_done,
   output logic       framing_error,
`ifdef RX_PARITY_EN
   output logic       parity_error,
`endif
   output logic       overrun
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT
   } state_t;

   state_t state_q, state_d;

   logic              rx_meta_q, rx_s_q;
   logic              rx_s;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]        samp_cnt_q, samp_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tick, mid_start, bit_end;
   logic              par_bad;

   logic              shift_en, stop_smp, frame_ok;
   logic              push, pop, ovr_set, ferr_set, perr_set;

   logic              rx_done_q, framing_q, overrun_q, parity_q;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_pin;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign rx_s      = rx_s_q;
   assign tick      = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
   assign mid_start = (state_q == S_START) && tick && (samp_cnt_q == 4'd7);
   assign bit_end   = tick && (samp_cnt_q == 4'd15);

   // Oversample divider and per-bit tick counter; both held at zero while idle
   // so every frame is timed from its own start edge.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      samp_cnt_d = samp_cnt_q;
      if (state_q == S_IDLE) begin
         tick_cnt_d = '0;
         samp_cnt_d = '0;
      end else begin
         if (tick) tick_cnt_d = '0;
         else      tick_cnt_d = tick_cnt_q + TICK_W'(1);
         if (mid_start) samp_cnt_d = '0;
         else if (tick) samp_cnt_d = samp_cnt_q + 4'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!rx_s) state_d = S_START;
         S_START:  if (mid_start) state_d = rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: if (bit_end) state_d = S_STOP;
`endif
         S_STOP:   if (bit_end) state_d = rx_s ? S_IDLE : S_WAIT;
         S_WAIT:   if (rx_s) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs: sampling strobes and the end-of-frame decision. A pop in the
   // same cycle frees a slot, so a full FIFO still accepts the byte then.
   always_comb begin
      shift_en = (state_q == S_DATA) && bit_end;
      stop_smp = (state_q == S_STOP) && bit_end;
      pop      = read_enable && (count_q != '0);
      frame_ok = stop_smp && rx_s && !par_bad;
      push     = frame_ok && ((count_q != CNT_FULL) || pop);
      ovr_set  = frame_ok && (count_q == CNT_FULL) && !pop;
      ferr_set = stop_smp && !rx_s;
      perr_set = stop_smp && par_bad;
   end

   // Bit index and shift register next values.
   always_comb begin
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      if (mid_start) begin
         bit_idx_d = 3'd0;
      end else if (shift_en) begin
         shift_d[bit_idx_q] = rx_s;
         bit_idx_d          = bit_idx_q + 3'd1;
      end
   end

   // Deserialiser registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_q <= '0;
         samp_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         samp_cnt_q <= samp_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
      end
   end

`ifdef RX_PARITY_EN
   logic par_bad_q, par_bad_d;

   // Parity verdict is held from the parity sample until the stop decision.
   always_comb begin
      par_bad_d = par_bad_q;
      if (state_q == S_IDLE)
         par_bad_d = 1'b0;
      else if ((state_q == S_PARITY) && bit_end)
         par_bad_d = (rx_s != (^shift_q));
   end

   // Parity verdict register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_bad_q <= 1'b0;
      else      par_bad_q <= par_bad_d;
   end

   assign par_bad      = par_bad_q;
   assign parity_error = parity_q;
`else
   assign par_bad = 1'b0;
`endif

   // Status pulses, one cycle after the stop-sample tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_done_q <= 1'b0;
         framing_q <= 1'b0;
         overrun_q <= 1'b0;
         parity_q  <= 1'b0;
      end else begin
         rx_done_q <= push;
         framing_q <= ferr_set;
         overrun_q <= ovr_set;
         parity_q  <= perr_set;
      end
   end

   // FIFO occupancy next value.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage and pointers; storage is cleared so dout is 0 out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   assign dout          = mem_q[rd_ptr_q];
   assign fifo_empty    = (count_q == '0);
   assign fifo_full     = (count_q == CNT_FULL);
   assign rx_done       = rx_done_q;
   assign framing_error = framing_q;
   assign overrun       = overrun_q;

endmodule
